gate_checker: RTL and testbench

Self-checking response monitor for the Chapter 1 basic-gate bench. It samples each applied input pair and the five gate outputs (Not, Nand, And, Or, Xor) on a valid strobe and compares them against a built-in golden model. It accumulates mismatches and input-combination coverage, then reports done/pass once all four (a, b) combinations have been observed. It sits at the receive end of the gate stimulus path, replacing manual `$monitor` inspection with a registered verdict.

---
 rtl/gate_pkg.sv | 28 ++
 rtl/gate_ref.sv | 21 ++
 rtl/gate_checker.sv | 118 +++++++++++
 tb/tb_gate_checker.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the basic-gate response checker.
// State encoding, gate bit indices and small helpers.
package gate_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NOT  = 0;
  localparam int NAND = 1;
  localparam int AND  = 2;
  localparam int OR   = 3;
  localparam int XOR  = 4;

  localparam int GATE_N = 5;

  typedef logic [GATE_N-1:0] gvec_t;

  // one-hot coverage bit for a {b,a} pair
  function automatic logic [3:0] cov_bit(
    input logic [1:0] ab
  );
    return 4'b0001 << ab;
  endfunction

endpackage

// File: rtl/gate_ref.sv
// Golden model for the five basic gates.
// Output bits follow the gate index order of gate_pkg.
module gate_ref
  import gate_pkg::*;
(
  input  logic  a,
  input  logic  b,
  output gvec_t expv
);

  // expected gate outputs for the applied pair
  always_comb begin
    expv       = '0;
    expv[NOT]  = ~a;
    expv[NAND] = ~(a & b);
    expv[AND]  = a & b;
    expv[OR]   = a | b;
    expv[XOR]  = a ^ b;
  end

endmodule

// File: rtl/gate_checker.sv
// Response checker: scores gate outputs against gate_ref,
// tracks pair coverage and reports a registered verdict.
module gate_checker
  import gate_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             finish,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             anot,
  input  logic             abnand,
  input  logic             aband,
  input  logic             abor,
  input  logic             abxor,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       cov,
  output logic [1:0]       first_err_ab,
  output logic [4:0]       first_err_mask
);

  localparam logic [CNT_W-1:0] ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  state_t     state_nxt;
  gvec_t      expv;
  gvec_t      obsv;
  gvec_t      mask;
  logic [1:0] ab;
  logic [3:0] cov_nxt;
  logic       sample;
  logic       miss;
  logic       sat;
  logic       clr;

  gate_ref u_ref (
    .a    (a),
    .b    (b),
    .expv (expv)
  );

  assign ab      = {b, a};
  assign sample  = (state == RUN) && in_valid;
  assign mask    = expv ^ obsv;
  assign miss    = |mask;
  assign sat     = &err_count;
  assign cov_nxt = cov | cov_bit(ab);
  assign clr     = (state != RUN) && start;

  // pack observed outputs in gate index order
  always_comb begin
    obsv       = '0;
    obsv[NOT]  = anot;
    obsv[NAND] = abnand;
    obsv[AND]  = aband;
    obsv[OR]   = abor;
    obsv[XOR]  = abxor;
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state: run until full coverage or early finish
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (finish)
          state_nxt = DONE;
        else if (sample && cov_nxt == 4'hF)
          state_nxt = DONE;
      end
      DONE: if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // status outputs decoded from state and scores
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
    pass = done && (cov == 4'hF) &&
           (err_count == '0);
  end

  // score samples: counter, coverage, first error
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      err_count      <= '0;
      cov            <= '0;
      first_err_ab   <= '0;
      first_err_mask <= '0;
    end else if (sample) begin
      cov <= cov_nxt;
      if (miss) begin
        if (!sat)
          err_count <= err_count + ONE;
        if (err_count == '0) begin
          first_err_ab   <= ab;
          first_err_mask <= mask;
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_checker.sv
// Directed bench for gate_checker with a scoreboard queue.
// A reference model predicts outputs at each driven step.
module tb_gate_checker;

  logic       clk = 1'b0;
  logic       reset, start, finish, in_valid;
  logic       a, b;
  logic       anot, abnand, aband, abor, abxor;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic [3:0] cov;
  logic [1:0] first_err_ab;
  logic [4:0] first_err_mask;
  logic       busy2, done2, pass2;
  logic [1:0] err2;
  logic [3:0] cov2;
  logic [1:0] fab2;
  logic [4:0] fmask2;

  always #5 clk = ~clk;

  gate_checker #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .finish(finish), .in_valid(in_valid),
    .a(a), .b(b), .anot(anot), .abnand(abnand),
    .aband(aband), .abor(abor), .abxor(abxor),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .cov(cov),
    .first_err_ab(first_err_ab),
    .first_err_mask(first_err_mask)
  );

  gate_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start),
    .finish(finish), .in_valid(in_valid),
    .a(a), .b(b), .anot(anot), .abnand(abnand),
    .aband(aband), .abor(abor), .abxor(abxor),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .cov(cov2),
    .first_err_ab(fab2),
    .first_err_mask(fmask2)
  );

  typedef struct {
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err;
    logic [3:0] cov;
    logic [1:0] fab;
    logic [4:0] fmask;
    logic [1:0] err2;
    logic       pass2;
  } exp_t;

  exp_t q[$];

  int errors = 0;
  int checks = 0;

  // model state: 0 idle, 1 run, 2 done
  int         m_st = 0;
  int         m_err = 0;
  int         m_err2 = 0;
  logic [3:0] m_cov = '0;
  logic [1:0] m_fab = '0;
  logic [4:0] m_fmask = '0;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, got, want);
    end
  endtask

  task automatic m_clear();
    m_err = 0; m_err2 = 0; m_cov = '0;
    m_fab = '0; m_fmask = '0;
  endtask

  // one clock: drive, predict, push, clock, pop, compare
  task automatic step(input bit rst, input bit st,
                      input bit fin, input bit v,
                      input bit [1:0] ba,
                      input bit [4:0] flip,
                      input bit or0);
    logic [4:0] g, o, m;
    exp_t e, r;
    g = {ba[0] ^ ba[1], ba[0] | ba[1], ba[0] & ba[1],
         ~(ba[0] & ba[1]), ~ba[0]};
    o = g ^ flip;
    if (or0) o[3] = 1'b0;
    reset = rst; start = st; finish = fin;
    in_valid = v; a = ba[0]; b = ba[1];
    {abxor, abor, aband, abnand, anot} = o;
    if (rst) begin
      m_st = 0; m_clear();
    end else if (m_st != 1) begin
      if (st) begin
        m_st = 1; m_clear();
      end
    end else begin
      if (v) begin
        for (int i = 0; i < 5; i++)
          m[i] = (o[i] !== g[i]);
        if (m != 0) begin
          if (m_err == 0) begin
            m_fab = ba; m_fmask = m;
          end
          if (m_err < 255) m_err++;
          if (m_err2 < 3) m_err2++;
        end
        m_cov[ba] = 1'b1;
      end
      if (fin || m_cov == 4'hF) m_st = 2;
    end
    e.busy  = (m_st == 1);
    e.done  = (m_st == 2);
    e.pass  = e.done && m_cov == 4'hF && m_err == 0;
    e.pass2 = e.done && m_cov == 4'hF && m_err2 == 0;
    e.err   = 8'(m_err);
    e.err2  = 2'(m_err2);
    e.cov   = m_cov;
    e.fab   = m_fab;
    e.fmask = m_fmask;
    q.push_back(e);
    @(posedge clk);
    #1;
    r = q.pop_front();
    chk("busy", {7'd0, busy}, {7'd0, r.busy});
    chk("done", {7'd0, done}, {7'd0, r.done});
    chk("pass", {7'd0, pass}, {7'd0, r.pass});
    chk("err_count", err_count, r.err);
    chk("cov", {4'd0, cov}, {4'd0, r.cov});
    chk("first_err_ab", {6'd0, first_err_ab},
        {6'd0, r.fab});
    chk("first_err_mask", {3'd0, first_err_mask},
        {3'd0, r.fmask});
    chk("err_count_w2", {6'd0, err2}, {6'd0, r.err2});
    chk("pass_w2", {7'd0, pass2}, {7'd0, r.pass2});
    chk("done_w2", {7'd0, done2}, {7'd0, r.done});
  endtask

  task automatic idle(input bit st, input bit fin);
    step(1'b0, st, fin, 1'b0, 2'd0, 5'd0, 1'b0);
  endtask

  task automatic smp(input bit [1:0] ba,
                     input bit [4:0] flip,
                     input bit or0);
    step(1'b0, 1'b0, 1'b0, 1'b1, ba, flip, or0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; finish = 1'b0;
    in_valid = 1'b0; a = 1'b0; b = 1'b0;
    {abxor, abor, aband, abnand, anot} = '0;
    @(posedge clk); #1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
    chk("reset_state_done", {7'd0, done}, 8'd0);
    chk("reset_err", err_count, 8'd0);

    // idle: sample and finish ignored
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 5'h1F, 1'b0);
    idle(1'b0, 1'b1);

    // clean sweep -> cov 1,3,7,F then pass
    idle(1'b1, 1'b0);
    for (int k = 0; k < 4; k++)
      smp(2'(k), 5'd0, 1'b0);
    chk("sweep_pass", {7'd0, pass}, 8'd1);
    chk("sweep_cov", {4'd0, cov}, 8'h0F);
    idle(1'b0, 1'b0);

    // OR stuck at 0 from DONE restart
    idle(1'b1, 1'b0);
    for (int k = 0; k < 4; k++)
      smp(2'(k), 5'd0, 1'b1);
    chk("or0_err", err_count, 8'd3);
    chk("or0_fab", {6'd0, first_err_ab}, 8'h01);
    chk("or0_fmask", {3'd0, first_err_mask}, 8'h08);
    chk("or0_pass", {7'd0, pass}, 8'd0);

    // partial coverage then finish
    idle(1'b1, 1'b0);
    smp(2'd0, 5'd0, 1'b0);
    smp(2'd0, 5'd0, 1'b0);
    smp(2'd1, 5'd0, 1'b0);
    idle(1'b0, 1'b1);
    chk("early_cov", {4'd0, cov}, 8'h03);
    chk("early_done", {7'd0, done}, 8'd1);

    // all inverted, narrow counter saturates
    idle(1'b1, 1'b0);
    for (int k = 0; k < 5; k++)
      smp(2'd0, 5'h1F, 1'b0);
    smp(2'd1, 5'h1F, 1'b0);
    idle(1'b0, 1'b1);
    chk("sat_w2", {6'd0, err2}, 8'd3);
    chk("sat_w8", err_count, 8'd6);

    // reset mid-run, restart, ignored start mid-run
    idle(1'b1, 1'b0);
    smp(2'd0, 5'h01, 1'b0);
    smp(2'd1, 5'd0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 5'h1F, 1'b0);
    chk("rst_cov", {4'd0, cov}, 8'd0);
    smp(2'd3, 5'h1F, 1'b0);
    idle(1'b1, 1'b0);
    smp(2'd0, 5'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd0, 1'b0);
    smp(2'd2, 5'd0, 1'b0);
    smp(2'd3, 5'd0, 1'b0);
    chk("restart_pass", {7'd0, pass}, 8'd1);

    // finish together with the completing sample
    idle(1'b1, 1'b0);
    smp(2'd0, 5'd0, 1'b0);
    smp(2'd1, 5'd0, 1'b0);
    smp(2'd2, 5'h04, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 5'd0, 1'b0);
    idle(1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
